// File: rtl/rv64g_pkg.sv
// Shared rv64g issue-stage definitions: architectural register count and
// the lock tracker's block-state encoding.
package rv64g_pkg;

    localparam int unsigned NUM_REGS = 32;

    typedef enum logic {
        NORMAL  = 1'b0,
        BLOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/reg_wr_counter.sv
// Outstanding-write counter for one destination register: one increment and
// a multi-port decrement per cycle, saturating at zero.
module reg_wr_counter #(
    parameter int unsigned CW = 2,
    parameter int unsigned DW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic [DW-1:0] dec_i,
    output logic          nonzero_o,
    output logic          full_o,
    output logic          underflow_o
);

    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_sum;
    logic [CW:0]   w_dec;
    logic [CW-1:0] w_next;

    // Work one bit wider so an issue and a writeback in the same cycle net out
    // before the underflow test.
    always_comb begin
        w_sum       = {1'b0, r_cnt} + (CW+1)'(inc_i);
        w_dec       = (CW+1)'(dec_i);
        underflow_o = (w_sum < w_dec);
        w_next      = '0;
        if (!underflow_o) begin
            w_next = CW'(w_sum - w_dec);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign nonzero_o = (r_cnt != '0);
    assign full_o    = (r_cnt == '1);

endmodule

// File: rtl/reg_lock_tracker.sv
// Register lock tracker: per-register outstanding-write counters feeding the
// lock vector, plus a global block state held from a blocking issue to unblock.
module reg_lock_tracker
    import rv64g_pkg::*;
#(
    parameter int unsigned NR = NUM_REGS,
    parameter int unsigned NW = 2,
    parameter int unsigned CW = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    input  logic [$clog2(NR)-1:0]    issue_rd_i,
    input  logic                     issue_blocking_i,
    output logic                     issue_ready_o,
    input  logic [NW-1:0]            wb_valid_i,
    input  logic [NW*$clog2(NR)-1:0] wb_rd_i,
    input  logic                     unblock_i,
    output logic [NR-1:0]            locks_o,
    output logic                     wb_err_o
);

    localparam int unsigned RW = $clog2(NR);
    localparam int unsigned DW = $clog2(NW + 1);

    lock_state_e r_state;
    lock_state_e w_state_next;
    logic        r_wb_err;
    logic        w_accept;

    // x0 has no counter; its slots are simply absent from these vectors.
    logic [NR-1:1] w_inc;
    logic [NR-1:1] w_nonzero;
    logic [NR-1:1] w_full;
    logic [NR-1:1] w_underflow;
    logic [NR-1:0] w_full_all;
    logic [DW-1:0] w_dec [1:NR-1];

    assign w_full_all    = {w_full, 1'b0};
    assign issue_ready_o = (r_state == NORMAL) && ((issue_rd_i == '0) || !w_full_all[issue_rd_i]);
    assign w_accept      = issue_valid_i && issue_ready_o;

    always_comb begin
        for (int unsigned r = 1; r < NR; r++) begin
            w_inc[r] = w_accept && (issue_rd_i == RW'(r));
            w_dec[r] = '0;
            for (int unsigned p = 0; p < NW; p++) begin
                if (wb_valid_i[p] && (wb_rd_i[p*RW +: RW] == RW'(r))) begin
                    w_dec[r] = w_dec[r] + DW'(1);
                end
            end
        end
    end

    for (genvar g = 1; g < NR; g++) begin : g_cnt
        reg_wr_counter #(
            .CW (CW),
            .DW (DW)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .inc_i       (w_inc[g]),
            .dec_i       (w_dec[g]),
            .nonzero_o   (w_nonzero[g]),
            .full_o      (w_full[g]),
            .underflow_o (w_underflow[g])
        );
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            NORMAL:  if (w_accept && issue_blocking_i) w_state_next = BLOCKED;
            BLOCKED: if (unblock_i) w_state_next = NORMAL;
            default: w_state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= NORMAL;
            r_wb_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_wb_err <= |w_underflow;
        end
    end

    assign locks_o  = {w_nonzero, 1'b0} | {NR{r_state == BLOCKED}};
    assign wb_err_o = r_wb_err;

endmodule
